// File: rtl/full_subtractor.sv
// Registered ripple-borrow subtractor: {borrow, sub} = a - b - carry_in, one-cycle latency.
// Built from identical single-bit full-subtractor cells chained LSB to MSB.

module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module full_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sub,
  output logic             borrow,
  output logic             out_valid,
  output logic             zero
);
  logic [WIDTH:0]   bin;
  logic [WIDTH-1:0] d;

  assign bin[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (bin[i]),
      .d    (d[i]),
      .bout (bin[i+1])
    );
  end

  // Result registers only load on valid ops, so non-valid cycles hold the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub       <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sub    <= d;
        borrow <= bin[WIDTH];
        zero   <= ~|d;
      end
    end
  end
endmodule

// File: tb/tb_full_subtractor.sv
// Directed checks of full_subtractor at WIDTH=1, WIDTH=8 and a chained pair of WIDTH=4 cells.
module tb_full_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // WIDTH=1
  logic v1 = 0, a1 = 0, b1 = 0, c1 = 0;
  logic s1, bo1, ov1, z1;
  full_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .carry_in(c1),
    .sub(s1), .borrow(bo1), .out_valid(ov1), .zero(z1));

  // WIDTH=8
  logic       v8 = 0, c8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic [7:0] s8;
  logic       bo8, ov8, z8;
  full_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .carry_in(c8),
    .sub(s8), .borrow(bo8), .out_valid(ov8), .zero(z8));

  // Chained WIDTH=4 pair: low borrow feeds high carry_in one cycle later
  logic       vlo = 0, clo = 0, vhi = 0;
  logic [3:0] alo = 0, blo = 0, ahi = 0, bhi = 0;
  logic [3:0] slo, shi;
  logic       bolo, bohi, ovlo, ovhi, zlo, zhi;
  full_subtractor #(.WIDTH(4)) u_lo (
    .clk(clk), .rst(rst), .in_valid(vlo), .a(alo), .b(blo), .carry_in(clo),
    .sub(slo), .borrow(bolo), .out_valid(ovlo), .zero(zlo));
  full_subtractor #(.WIDTH(4)) u_hi (
    .clk(clk), .rst(rst), .in_valid(vhi), .a(ahi), .b(bhi), .carry_in(bolo),
    .sub(shi), .borrow(bohi), .out_valid(ovhi), .zero(zhi));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; v1 = 1; a1 = 1; b1 = 0; c1 = 0;
    step(); step();
    total++;
    if ({s1, bo1, z1, ov1} !== 4'b0010)
      $display("FAIL reset_w1: got sub=%b borrow=%b zero=%b ov=%b, want 0 0 1 0", s1, bo1, z1, ov1);
    else passed++;
    total++;
    if ({s8, bo8, z8, ov8} !== {8'h00, 3'b010})
      $display("FAIL reset_w8: got sub=%h borrow=%b zero=%b ov=%b, want 00 0 1 0", s8, bo8, z8, ov8);
    else passed++;
    rst = 0; a1 = 1; b1 = 1; c1 = 1;
    step();
    total++;
    if ({s1, bo1, ov1} !== 3'b111)
      $display("FAIL reset_release: got sub=%b borrow=%b ov=%b, want 1 1 1", s1, bo1, ov1);
    else passed++;
    v1 = 0;
  endtask

  task automatic test_exhaustive_w1();
    logic [7:0] exp_s, exp_b;
    logic [2:0] v;
    exp_s = 8'b1001_0110; // bit i = sub for {a,b,cin}=i
    exp_b = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      v1 = 1; a1 = v[2]; b1 = v[1]; c1 = v[0];
      step();
      total++;
      if ({s1, bo1, ov1} !== {exp_s[i], exp_b[i], 1'b1})
        $display("FAIL exh_w1_%0d: got sub=%b borrow=%b ov=%b, want %b %b 1",
                 i, s1, bo1, ov1, exp_s[i], exp_b[i]);
      else passed++;
    end
    v1 = 0;
  endtask

  task automatic test_hold();
    v1 = 1; a1 = 1; b1 = 0; c1 = 0;
    step();
    v1 = 0;
    for (int i = 0; i < 3; i++) begin
      a1 = ~a1; b1 = ~b1;
      step();
      total++;
      if ({s1, bo1, z1, ov1} !== 4'b1000)
        $display("FAIL hold_%0d: got sub=%b borrow=%b zero=%b ov=%b, want 1 0 0 0", i, s1, bo1, z1, ov1);
      else passed++;
    end
  endtask

  task automatic test_boundaries_w8();
    logic [7:0] ta [4], tb [4], es [4];
    logic       tc [4], eb [4], ez [4];
    ta = '{8'h00, 8'h00, 8'h80, 8'h5A}; tb = '{8'h00, 8'hFF, 8'h7F, 8'h5A};
    tc = '{1'b1, 1'b1, 1'b0, 1'b0};
    es = '{8'hFF, 8'h00, 8'h01, 8'h00};
    eb = '{1'b1, 1'b1, 1'b0, 1'b0};
    ez = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      v8 = 1; a8 = ta[i]; b8 = tb[i]; c8 = tc[i];
      step();
      total++;
      if ({s8, bo8, z8, ov8} !== {es[i], eb[i], ez[i], 1'b1})
        $display("FAIL bound_w8_%0d: got sub=%h borrow=%b zero=%b ov=%b, want %h %b %b 1",
                 i, s8, bo8, z8, ov8, es[i], eb[i], ez[i]);
      else passed++;
    end
    v8 = 0;
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    int errs = 0;
    for (int i = 0; i < 1000; i++) begin
      v8 = 1; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      exp = 9'(({1'b0, a8} - {1'b0, b8} - 9'(c8)) & 9'h1FF);
      step();
      total++;
      if ({ov8, bo8, s8} !== {1'b1, exp}) begin
        if (errs < 10)
          $display("FAIL b2b_%0d: got ov=%b {borrow,sub}=%h, want 1 %h", i, ov8, {bo8, s8}, exp);
        errs++;
      end else passed++;
    end
    v8 = 0;
  endtask

  task automatic test_mid_reset();
    v8 = 1; a8 = 8'h33; b8 = 8'h11; c8 = 0;
    step();
    rst = 1;
    step();
    rst = 0; v8 = 0;
    total++;
    if ({s8, bo8, z8, ov8} !== {8'h00, 3'b010})
      $display("FAIL mid_reset: got sub=%h borrow=%b zero=%b ov=%b, want 00 0 1 0", s8, bo8, z8, ov8);
    else passed++;
    step();
    total++;
    if (ov8 !== 1'b0)
      $display("FAIL mid_reset_idle: got ov=%b, want 0", ov8);
    else passed++;
  endtask

  task automatic test_chain();
    vlo = 1; alo = 4'h0; blo = 4'h1; clo = 0;
    v8 = 1; a8 = 8'h10; b8 = 8'h01; c8 = 0;
    step();
    vlo = 0; v8 = 0;
    vhi = 1; ahi = 4'h1; bhi = 4'h0;
    step();
    vhi = 0;
    total++;
    if ({shi, slo, bohi, ovhi} !== {8'h0F, 1'b0, 1'b1})
      $display("FAIL chain: got sub=%h borrow=%b ov=%b, want 0f 0 1", {shi, slo}, bohi, ovhi);
    else passed++;
    total++;
    if ({s8, bo8} !== {8'h0F, 1'b0})
      $display("FAIL chain_ref_w8: got sub=%h borrow=%b, want 0f 0", s8, bo8);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_exhaustive_w1();
    test_hold();
    test_boundaries_w8();
    test_back_to_back();
    test_mid_reset();
    test_chain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
